// File: rtl/servo_replay_sequencer.sv
// Purpose : records live 4-channel servo poses into a small table and replays them as rate-limited moves with a hold per pose.
// Latency : IDLE outputs are a 1-cycle registered copy of i_servo*; during replay each i_tick moves each channel by at most STEP.
// Backpres: none; single-cycle command pulses act immediately, and pulses that cannot act are dropped.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_tick                 motion strobe; steps MOVE and counts HOLD
//   i_record/i_play/i_clear command pulses (IDLE priority: play > clear > record)
//   i_servo0..3            live positions from the manual controller
//   o_servo0..3            positions to the PWM generators
//   o_replaying            registered, high while in MOVE or HOLD
//   o_tot_state            number of stored poses
//   o_cur_state            index of the pose being replayed
//   o_full                 table full (combinational from the pose count)
//
// Build option: define REPLAY_LOOP_EN to restart from pose 0 after the last
// pose instead of returning to IDLE.
module servo_replay_sequencer #(
    parameter int DEPTH      = 16,
    parameter int W          = 13,
    parameter int STEP       = 5,
    parameter int HOLD_TICKS = 20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_record,
    input  logic         i_play,
    input  logic         i_clear,
    input  logic [W-1:0] i_servo0,
    input  logic [W-1:0] i_servo1,
    input  logic [W-1:0] i_servo2,
    input  logic [W-1:0] i_servo3,
    output logic [W-1:0] o_servo0,
    output logic [W-1:0] o_servo1,
    output logic [W-1:0] o_servo2,
    output logic [W-1:0] o_servo3,
    output logic         o_replaying,
    output logic [4:0]   o_tot_state,
    output logic [4:0]   o_cur_state,
    output logic         o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [W-1:0]        RST_POS   = W'(150);
    localparam logic [W-1:0]        STEP_W    = W'(STEP);
    localparam logic signed [W:0]   STEP_S    = (W+1)'(STEP);
    localparam logic [4:0]          DEPTH_C   = 5'(DEPTH);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef logic [3:0][W-1:0] pose_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    pose_t           servo_q, servo_d;
    logic [4:0]      tot_q, tot_d;
    logic [4:0]      cur_q, cur_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            replaying_q, replaying_d;

    pose_t           pose_mem [DEPTH];
    pose_t           live_pose;
    pose_t           target;
    pose_t           stepped;
    logic signed [W:0] diff [4];
    logic            wr_en;
    logic            full;
    logic            at_target;
    logic            hold_done;
    logic            last_pose;

    assign live_pose = {i_servo3, i_servo2, i_servo1, i_servo0};
    assign full      = (tot_q == DEPTH_C);
    assign target    = pose_mem[cur_q[AW-1:0]];
    assign at_target = (servo_q == target);
    assign hold_done = (hold_q == HOLD_LAST);
    // cur+1 >= tot rather than cur == tot-1 so an empty table cannot underflow.
    assign last_pose = (5'(cur_q + 5'd1) >= tot_q);

    // One rate-limited step per channel. The W+1-bit signed difference
    // covers the full unsigned range in both directions, and a step is only
    // taken when the target is more than STEP away, so the add/subtract
    // never wraps.
    always_comb begin
        stepped = servo_q;
        for (int ch = 0; ch < 4; ch++) begin
            diff[ch] = $signed({1'b0, target[ch]}) - $signed({1'b0, servo_q[ch]});
            if (diff[ch] > STEP_S) begin
                stepped[ch] = servo_q[ch] + STEP_W;
            end else if (diff[ch] < -STEP_S) begin
                stepped[ch] = servo_q[ch] - STEP_W;
            end else begin
                stepped[ch] = target[ch];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_play && (tot_q != 5'd0)) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (i_play) begin
                    state_d = ST_IDLE;
                end else if (at_target) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_play) begin
                    state_d = ST_IDLE;
                end else if (i_tick && hold_done) begin
                    if (last_pose) begin
`ifdef REPLAY_LOOP_EN
                        state_d = ST_MOVE;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        servo_d     = servo_q;
        tot_d       = tot_q;
        cur_d       = cur_q;
        hold_d      = hold_q;
        wr_en       = 1'b0;
        replaying_d = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                servo_d = live_pose;
                if (i_play) begin
                    // An empty table makes play a no-op; clear/record are
                    // still dropped because play outranks them.
                    if (tot_q != 5'd0) begin
                        cur_d   = 5'd0;
                        servo_d = servo_q;  // motion starts from where we are
                    end
                end else if (i_clear) begin
                    tot_d = 5'd0;
                    cur_d = 5'd0;
                end else if (i_record && !full) begin
                    wr_en = 1'b1;
                    tot_d = 5'(tot_q + 5'd1);
                end
            end
            ST_MOVE: begin
                if (!i_play) begin
                    if (at_target) begin
                        hold_d = '0;
                    end else if (i_tick) begin
                        servo_d = stepped;
                    end
                end
            end
            ST_HOLD: begin
                if (!i_play && i_tick) begin
                    if (hold_done) begin
                        hold_d = '0;
                        cur_d  = last_pose ? 5'd0 : 5'(cur_q + 5'd1);
                    end else begin
                        hold_d = HW'(hold_q + 1'b1);
                    end
                end
            end
            default: begin
                servo_d = servo_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            servo_q     <= {4{RST_POS}};
            tot_q       <= 5'd0;
            cur_q       <= 5'd0;
            hold_q      <= '0;
            replaying_q <= 1'b0;
        end else begin
            servo_q     <= servo_d;
            tot_q       <= tot_d;
            cur_q       <= cur_d;
            hold_q      <= hold_d;
            replaying_q <= replaying_d;
        end
    end

    // Pose table has no reset; unwritten slots are never read because
    // replay only visits indices below the pose count.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            pose_mem[tot_q[AW-1:0]] <= live_pose;
        end
    end

    assign o_servo0    = servo_q[0];
    assign o_servo1    = servo_q[1];
    assign o_servo2    = servo_q[2];
    assign o_servo3    = servo_q[3];
    assign o_replaying = replaying_q;
    assign o_tot_state = tot_q;
    assign o_cur_state = cur_q;
    assign o_full      = full;

endmodule

// File: tb/tb_servo_replay_sequencer.sv
module tb_servo_replay_sequencer;

    localparam int W          = 13;
    localparam int DEPTH      = 16;
    localparam int STEP       = 5;
    localparam int HOLD_TICKS = 20;
    localparam int MAXV       = (1 << W) - 1;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_tick = 1'b0, i_record = 1'b0, i_play = 1'b0, i_clear = 1'b0;
    logic [W-1:0] i_servo0 = '0, i_servo1 = '0, i_servo2 = '0, i_servo3 = '0;
    logic [W-1:0] o_servo0, o_servo1, o_servo2, o_servo3;
    logic         o_replaying, o_full;
    logic [4:0]   o_tot_state, o_cur_state;

    int checks = 0;
    int errors = 0;

    // Reference model: stored poses, expected outputs, current live inputs.
    int tab_m [DEPTH][4];
    int tot_m = 0;
    int exp_o [4];
    int live  [4];

    servo_replay_sequencer #(
        .DEPTH(DEPTH), .W(W), .STEP(STEP), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
        .i_record(i_record), .i_play(i_play), .i_clear(i_clear),
        .i_servo0(i_servo0), .i_servo1(i_servo1), .i_servo2(i_servo2), .i_servo3(i_servo3),
        .o_servo0(o_servo0), .o_servo1(o_servo1), .o_servo2(o_servo2), .o_servo3(o_servo3),
        .o_replaying(o_replaying), .o_tot_state(o_tot_state),
        .o_cur_state(o_cur_state), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dut_out(input int ch);
        case (ch)
            0: return int'(o_servo0);
            1: return int'(o_servo1);
            2: return int'(o_servo2);
            default: return int'(o_servo3);
        endcase
    endfunction

    function automatic bit outs_match(input int v [4]);
        for (int ch = 0; ch < 4; ch++) if (dut_out(ch) != v[ch]) return 1'b0;
        return 1'b1;
    endfunction

    // Rate-limited move rule written directly from the behaviour description.
    function automatic int step_to(input int pos, input int tgt);
        if (tgt - pos > STEP) return pos + STEP;
        if (pos - tgt > STEP) return pos - STEP;
        return tgt;
    endfunction

    task automatic drive_live(input int a, input int b, input int c, input int d);
        live[0] = a; live[1] = b; live[2] = c; live[3] = d;
        i_servo0 = W'(a); i_servo1 = W'(b); i_servo2 = W'(c); i_servo3 = W'(d);
    endtask

    task automatic drive_rand(input int hi);
        drive_live(int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
                   int'($urandom_range(0, hi)), int'($urandom_range(0, hi)));
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic t, input logic p, input logic r, input logic c);
        i_tick = t; i_play = p; i_record = r; i_clear = c;
        @(posedge i_clk); #1;
        i_tick = 1'b0; i_play = 1'b0; i_record = 1'b0; i_clear = 1'b0;
    endtask

    // Model side of an IDLE record pulse with the current live inputs.
    task automatic model_record();
        if (tot_m < DEPTH) begin
            for (int ch = 0; ch < 4; ch++) tab_m[tot_m][ch] = live[ch];
            tot_m++;
        end
        exp_o = live;
    endtask

    task automatic model_clear();
        tot_m = 0;
        exp_o = live;
    endtask

    // Starts replay from the current outputs and follows the whole sequence.
    task automatic play_and_verify(input string tag);
        int pos [4];
        int tgt [4];
        int n;
        pos = exp_o;
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_replaying !== 1'b1 || o_cur_state !== 5'd0) begin
            errors++;
            $display("FAIL %s_start: replaying=%0b cur=%0d, expected 1/0", tag, o_replaying, o_cur_state);
        end
        for (int p = 0; p < tot_m; p++) begin
            for (int ch = 0; ch < 4; ch++) tgt[ch] = tab_m[p][ch];
            n = 0;
            while ((pos[0] != tgt[0] || pos[1] != tgt[1] || pos[2] != tgt[2] || pos[3] != tgt[3]) && n < 5000) begin
                repeat ($urandom_range(1, 2)) begin
                    drive_rand(MAXV);
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                end
                cyc(1'b1, 1'b0, 1'b0, 1'b0);
                for (int ch = 0; ch < 4; ch++) pos[ch] = step_to(pos[ch], tgt[ch]);
                n++;
                checks++;
                if (!outs_match(pos)) begin
                    errors++;
                    $display("FAIL %s_move p%0d tick%0d: got %0d %0d %0d %0d, expected %0d %0d %0d %0d",
                             tag, p, n, o_servo0, o_servo1, o_servo2, o_servo3, pos[0], pos[1], pos[2], pos[3]);
                end
            end
            for (int h = 1; h <= HOLD_TICKS; h++) begin
                repeat ($urandom_range(1, 2)) begin
                    drive_rand(MAXV);
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                end
                cyc(1'b1, 1'b0, 1'b0, 1'b0);
                if (h == HOLD_TICKS - 1) begin
                    checks++;
                    if (o_replaying !== 1'b1 || o_cur_state !== 5'(p) || !outs_match(pos)) begin
                        errors++;
                        $display("FAIL %s_hold p%0d: replaying=%0b cur=%0d out0=%0d, expected 1/%0d/%0d",
                                 tag, p, o_replaying, o_cur_state, o_servo0, p, pos[0]);
                    end
                end
            end
            if (p < tot_m - 1) begin
                checks++;
                if (o_cur_state !== 5'(p + 1) || o_replaying !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_advance p%0d: cur=%0d replaying=%0b, expected %0d/1",
                             tag, p, o_cur_state, o_replaying, p + 1);
                end
            end
        end
`ifdef REPLAY_LOOP_EN
        checks++;
        if (o_cur_state !== 5'd0 || o_replaying !== 1'b1) begin
            errors++;
            $display("FAIL %s_loop: cur=%0d replaying=%0b, expected 0/1", tag, o_cur_state, o_replaying);
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_replaying !== 1'b0 || !outs_match(pos)) begin
            errors++;
            $display("FAIL %s_loop_abort: replaying=%0b out0=%0d, expected 0/%0d", tag, o_replaying, o_servo0, pos[0]);
        end
`else
        checks++;
        if (o_replaying !== 1'b0 || o_cur_state !== 5'd0 || !outs_match(pos)) begin
            errors++;
            $display("FAIL %s_end: replaying=%0b cur=%0d out0=%0d, expected 0/0/%0d",
                     tag, o_replaying, o_cur_state, o_servo0, pos[0]);
        end
`endif
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
        checks++;
        if (!outs_match(exp_o)) begin
            errors++;
            $display("FAIL %s_resume: got %0d %0d, expected %0d %0d", tag, o_servo0, o_servo3, exp_o[0], exp_o[3]);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive_live(0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        #1;
        exp_o = '{150, 150, 150, 150};
        checks++;
        if (!outs_match(exp_o)) begin
            errors++;
            $display("FAIL reset_servo: got %0d %0d %0d %0d, expected 150", o_servo0, o_servo1, o_servo2, o_servo3);
        end
        checks++;
        if (o_tot_state !== 5'd0 || o_cur_state !== 5'd0 || o_replaying !== 1'b0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: tot=%0d cur=%0d rep=%0b full=%0b, expected 0/0/0/0",
                     o_tot_state, o_cur_state, o_replaying, o_full);
        end
        i_rst = 1'b0;
        tot_m = 0;
    endtask

    task automatic test_passthrough();
        drive_live(200, 300, 400, 500);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
        checks++;
        if (!outs_match(exp_o) || o_tot_state !== 5'd0 || o_replaying !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_fixed: got %0d %0d %0d %0d tot=%0d rep=%0b, expected 200 300 400 500 0 0",
                     o_servo0, o_servo1, o_servo2, o_servo3, o_tot_state, o_replaying);
        end
        for (int k = 0; k < 8; k++) begin
            drive_rand(MAXV);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            exp_o = live;
            checks++;
            if (!outs_match(exp_o)) begin
                errors++;
                $display("FAIL passthrough_rand%0d: got %0d %0d %0d %0d, expected %0d %0d %0d %0d", k,
                         o_servo0, o_servo1, o_servo2, o_servo3, exp_o[0], exp_o[1], exp_o[2], exp_o[3]);
            end
        end
    endtask

    task automatic test_record_replay();
        drive_live(200, 150, 150, 150);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        drive_live(150, 150, 150, 150);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        checks++;
        if (o_tot_state !== 5'(tot_m)) begin
            errors++;
            $display("FAIL record_count: tot=%0d, expected %0d", o_tot_state, tot_m);
        end
        play_and_verify("two_pose");

        // Full-range swings exercise the signed difference at both extremes.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        model_clear();
        drive_live(MAXV, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        drive_live(0, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), MAXV);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        drive_rand(300);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        checks++;
        if (o_tot_state !== 5'd3) begin
            errors++;
            $display("FAIL record_count3: tot=%0d, expected 3", o_tot_state);
        end
        play_and_verify("extremes");
    endtask

    task automatic test_full_clear();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            drive_rand(400);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            model_record();
            checks++;
            if (o_tot_state !== 5'(k + 1) || o_full !== (k == DEPTH - 1)) begin
                errors++;
                $display("FAIL fill%0d: tot=%0d full=%0b, expected %0d/%0b", k, o_tot_state, o_full, k + 1, k == DEPTH - 1);
            end
        end
        drive_live(4000, 4000, 4000, 4000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        checks++;
        if (o_tot_state !== 5'(DEPTH) || o_full !== 1'b1) begin
            errors++;
            $display("FAIL overfill: tot=%0d full=%0b, expected %0d/1", o_tot_state, o_full, DEPTH);
        end
        play_and_verify("full_table");
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        model_clear();
        checks++;
        if (o_tot_state !== 5'd0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL clear: tot=%0d full=%0b, expected 0/0", o_tot_state, o_full);
        end
    endtask

    task automatic test_abort();
        int pos [4];
        drive_live(1000, 2000, 3000, 4000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        drive_live(100, 100, 100, 100);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
        pos = exp_o;
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            for (int ch = 0; ch < 4; ch++) pos[ch] = step_to(pos[ch], tab_m[0][ch]);
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_replaying !== 1'b0 || !outs_match(pos) || o_tot_state !== 5'(tot_m)) begin
            errors++;
            $display("FAIL abort_move: rep=%0b out0=%0d tot=%0d, expected 0/%0d/%0d", o_replaying, o_servo0, o_tot_state, pos[0], tot_m);
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
        checks++;
        if (!outs_match(exp_o)) begin
            errors++;
            $display("FAIL abort_resume: got %0d %0d, expected %0d %0d", o_servo0, o_servo3, exp_o[0], exp_o[3]);
        end

        // Abort from HOLD: start already on the stored pose.
        drive_live(1000, 2000, 3000, 4000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_replaying !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold_pre: rep=%0b, expected 1", o_replaying);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_replaying !== 1'b0 || o_tot_state !== 5'(tot_m)) begin
            errors++;
            $display("FAIL abort_hold: rep=%0b tot=%0d, expected 0/%0d", o_replaying, o_tot_state, tot_m);
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        model_clear();
        for (int k = 0; k < 2; k++) begin
            drive_rand(500);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            model_record();
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (o_replaying !== 1'b1 || o_tot_state !== 5'd2) begin
            errors++;
            $display("FAIL prio_play: rep=%0b tot=%0d, expected 1/2", o_replaying, o_tot_state);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        model_clear();
        checks++;
        if (o_tot_state !== 5'd0 || !outs_match(exp_o)) begin
            errors++;
            $display("FAIL prio_clear: tot=%0d out0=%0d, expected 0/%0d", o_tot_state, o_servo0, exp_o[0]);
        end
        drive_rand(MAXV);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        exp_o = live;
        checks++;
        if (o_replaying !== 1'b0 || o_tot_state !== 5'd0 || o_cur_state !== 5'd0 || !outs_match(exp_o)) begin
            errors++;
            $display("FAIL play_empty: rep=%0b tot=%0d cur=%0d out0=%0d, expected 0/0/0/%0d",
                     o_replaying, o_tot_state, o_cur_state, o_servo0, exp_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        drive_live(500, 600, 700, 800);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        model_record();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        exp_o = '{150, 150, 150, 150};
        checks++;
        if (!outs_match(exp_o) || o_tot_state !== 5'd0 || o_cur_state !== 5'd0 ||
            o_replaying !== 1'b0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out0=%0d tot=%0d cur=%0d rep=%0b full=%0b, expected 150/0/0/0/0",
                     o_servo0, o_tot_state, o_cur_state, o_replaying, o_full);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        tot_m = 0;
        drive_rand(MAXV);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_o = live;
        checks++;
        if (!outs_match(exp_o) || o_replaying !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out0=%0d rep=%0b, expected %0d/0", o_servo0, o_replaying, exp_o[0]);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_record_replay();
        test_full_clear();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_replay_sequencer.md
Name: servo_replay_sequencer

Overview:
Records snapshots of the four live servo positions into an on-chip pose table and replays them as a timed motion sequence. During replay it moves each servo toward the stored target at a bounded rate, holds at each pose, then advances. It sits between the keyboard-driven position controller and the PWM generators; o_replaying tells upstream logic to freeze manual control.

Parameters:
DEPTH, 16, number of pose slots (1..31)
W, 13, servo position width (same units as the PWM compare value)
STEP, 5, max change per channel per i_tick during MOVE
HOLD_TICKS, 20, i_tick count spent in HOLD at each reached pose (>=1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_tick  in  1  single-cycle motion strobe from the time divider
i_record  in  1  single-cycle pulse: capture the live pose
i_play  in  1  single-cycle pulse: start replay; aborts replay if already replaying
i_clear  in  1  single-cycle pulse: empty the pose table
i_servo0..i_servo3  in  W each  live positions from the manual controller
o_servo0..o_servo3  out  W each  positions sent to the PWM generators
o_replaying  out  1  high in MOVE or HOLD
o_tot_state  out  5  number of stored poses
o_cur_state  out  5  index of the pose being replayed
o_full  out  1  o_tot_state == DEPTH

Behaviour:
- Reset (async, i_rst=1):
  - o_servo* = 150; o_tot_state = 0; o_cur_state = 0; o_replaying = 0; o_full = 0.
  - FSM = IDLE; hold counter = 0.
  - Table contents are don't-care.
- All other logic is synchronous to i_clk rising edge.
- States are IDLE, MOVE and HOLD.
- IDLE:
  - o_servoN <= i_servoN every cycle (1-cycle registered pass-through).
  - i_record with tot < DEPTH: write {i_servo0..3} to slot tot; tot <= tot+1. The new count is visible the next cycle.
  - i_record when full: ignored, no wrap.
  - i_clear: tot <= 0, cur <= 0.
  - i_play with tot > 0: cur <= 0 and enter MOVE; o_servo* keep their current values as the motion start point.
  - i_play with tot == 0: ignored.
- Priority in IDLE when pulses coincide: i_play > i_clear > i_record. Only the highest-priority pulse acts; the others are dropped.
- MOVE:
  - The target is table[cur].
  - On each i_tick, each channel steps toward its target:
    - if |target - o_servoN| > STEP, move by STEP toward the target;
    - otherwise, set o_servoN to the target.
  - Use W+1-bit signed differences; no overflow or underflow is permitted.
  - Between ticks, outputs are held.
  - When all four channels equal their targets (checked every cycle), go to HOLD and clear the hold counter.
  - If the outputs already equal the target on entry, MOVE lasts one cycle.
- HOLD:
  - The hold counter increments on each i_tick.
  - When it reaches HOLD_TICKS:
    - if cur < tot-1: cur <= cur+1, go to MOVE;
    - else end of sequence: go to IDLE with cur <= 0.
- i_play in MOVE or HOLD: abort. Go to IDLE next cycle; outputs resume pass-through from the following cycle.
- i_record and i_clear are ignored in MOVE and HOLD. The table is never written during replay.
- o_replaying is registered and equals (state != IDLE).
- o_full is combinational from tot.
- i_servo* are ignored during replay.
- Reset asserted mid-replay returns everything to the reset values immediately.

Optional Feature:
REPLAY_LOOP_EN:
- Defined: at end of sequence (HOLD done and cur == tot-1), set cur <= 0 and go to MOVE, looping forever until an i_play abort or reset.
- Undefined: return to IDLE as described in Behaviour.
- Table and counter behaviour are otherwise identical.

Test Plan:
1. Reset, then live inputs {200,300,400,500} -> one cycle later o_servo = {200,300,400,500}; tot=0; o_replaying=0.
2. Record {200,150,150,150} then {150,150,150,150}; play from outputs {150,150,150,150} with STEP=5 -> o_servo0 rises 155, 160 … 200 over 10 ticks; HOLD 20 ticks; cur=1; falls back to 150 over 10 ticks; HOLD; IDLE with o_replaying=0.
3. Fill all 16 slots, then record a 17th time -> tot stays 16, o_full=1, slot 15 unchanged. Then clear -> tot=0, o_full=0.
4. i_play pulse in the middle of MOVE -> o_replaying drops within 1 cycle; outputs return to live inputs on the next cycle; tot is unchanged.
5. i_play and i_record in the same cycle with tot=2 -> replay starts, tot stays 2. i_play with tot=0 -> no state change.
6. With REPLAY_LOOP_EN defined and 2 poses -> after pose 1 HOLD, cur=0 and MOVE re-enters; abort with i_play. Also: assert i_rst during HOLD -> all outputs return to their reset values asynchronously.
